// File: rtl/bnn_xnor_neuron.sv
// bnn_xnor_neuron
// Serial binary neuron. Byte pairs of activations and weights arrive over a
// valid/ready handshake. Each pair is XNORed, the matching bits are counted,
// and the counts are summed over N_BYTES transfers. The total is then compared
// against a threshold to give a 1-bit activation. The result is held, together
// with its raw sum, until the downstream stage accepts it.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset (overrides everything)
//   clr        synchronous abort of any partial or held evaluation
//   in_valid   byte pair valid
//   in_ready   stage can accept a byte pair (high only while accumulating)
//   in_act     8 activation bits (1 = +1, 0 = -1)
//   in_wgt     8 weight bits, same encoding
//   thresh     firing threshold, sampled with the last byte of an evaluation
//   out_valid  result valid (high only while holding a result)
//   out_ready  downstream accepts the result
//   out_bit    1 iff sum >= thresh
//   out_sum    final match count, 0..8*N_BYTES
module bnn_xnor_neuron #(
  parameter int N_BYTES = 4,
  parameter int SUM_W   = $clog2(8 * N_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_act,
  input  logic [7:0]       in_wgt,
  input  logic [SUM_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SUM_W-1:0] out_sum
);

  localparam int CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       match;
  logic [3:0]       pc;
  logic [SUM_W-1:0] sum_next;
  logic             take;
  logic             last;

  // Count the agreeing bit positions of the current byte pair (0..8).
  always_comb begin
    match = ~(in_act ^ in_wgt);
    pc    = '0;
    for (int i = 0; i < 8; i++) begin
      pc = pc + {3'b000, match[i]};
    end
  end

  // SUM_W is wide enough for 8*N_BYTES, so this sum never overflows.
  assign sum_next = acc + SUM_W'(pc);
  assign take     = in_ready && in_valid;
  assign last     = take && (cnt == LAST_CNT);

  // in_ready and out_valid depend only on the state register. clr always
  // forces a return to accumulation, even if a last byte is offered.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
    if (clr) state_next = ACC;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // Accumulator and result registers. On clr, the result registers keep the
  // previous result, while any partial sum and the byte count are thrown away.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      out_bit <= 1'b0;
      out_sum <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      if (last) begin
        out_sum <= sum_next;
        out_bit <= (sum_next >= thresh);
        acc     <= '0;
        cnt     <= '0;
      end else begin
        acc <= sum_next;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bnn_xnor_neuron.sv
// tb_bnn_xnor_neuron
// Directed bench for bnn_xnor_neuron with the default parameters
// (N_BYTES=4, SUM_W=6). A transaction-level model counts matching bits per
// accepted byte and decides when a result is held. A compare process checks
// the DUT against this model on every falling edge. Literal expectations,
// worked out by hand for each scenario, pin the model itself.
module tb_bnn_xnor_neuron;

  localparam int N  = 4;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_act = '0;
  logic [7:0]    in_wgt = '0;
  logic [SW-1:0] thresh = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_bit;
  logic [SW-1:0] out_sum;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  bnn_xnor_neuron #(.N_BYTES(N), .SUM_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  // Behavioural model, updated on the rising edge: a byte is taken whenever
  // no result is held and in_valid is high. Its matching bits are added to a
  // running total. After N bytes the total becomes the result.
  bit m_holding = 1'b0;
  int m_count = 0;
  int m_total = 0;
  int m_sum = 0;
  bit m_bit = 1'b0;
  logic [7:0] m_match;

  always @(posedge clk) begin
    if (rst) begin
      m_holding = 1'b0;
      m_count = 0;
      m_total = 0;
      m_sum = 0;
      m_bit = 1'b0;
    end else if (clr) begin
      m_holding = 1'b0;
      m_count = 0;
      m_total = 0;
    end else if (m_holding) begin
      if (out_ready) m_holding = 1'b0;
    end else if (in_valid) begin
      m_match = ~(in_act ^ in_wgt);
      m_total = m_total + $countones(m_match);
      m_count = m_count + 1;
      if (m_count == N) begin
        m_sum = m_total;
        m_bit = (m_total >= int'(thresh));
        m_holding = 1'b1;
        m_count = 0;
        m_total = 0;
      end
    end
  end

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check_val("model in_ready", int'(in_ready), int'(!m_holding));
      check_val("model out_valid", int'(out_valid), int'(m_holding));
      check_val("model out_bit", int'(out_bit), int'(m_bit));
      check_val("model out_sum", int'(out_sum), m_sum);
    end
  end

  // Advance to just after the next rising edge; inputs always change here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one byte pair and keep it on the inputs until it is accepted.
  task automatic apply_stimulus(input logic [7:0] act, input logic [7:0] wgt,
                                input logic [SW-1:0] th);
    bit accepted = 1'b0;
    in_act = act;
    in_wgt = wgt;
    thresh = th;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !accepted; k++) begin
      accepted = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_act = 8'h5A;
    in_wgt = 8'hC3;
    if (!accepted) check_val("byte accept timeout", 0, 1);
  endtask

  task automatic send_eval(input logic [7:0] act, input logic [7:0] wgt,
                           input logic [SW-1:0] th, input bit gaps);
    for (int b = 0; b < N; b++) begin
      apply_stimulus(act, wgt, th);
      if (gaps && b == 1) begin
        step();
        step();
      end
    end
  endtask

  // Wait for a result (bounded) and compare it with hand-computed values.
  task automatic check_output(input string name, input int exp_sum, input int exp_bit);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    check_val({name, " out_valid"}, int'(out_valid), 1);
    check_val({name, " out_sum"}, int'(out_sum), exp_sum);
    check_val({name, " out_bit"}, int'(out_bit), exp_bit);
  endtask

  initial begin
    step();
    step();
    step();
    rst = 1'b0;
    check_en = 1'b1;
    check_val("reset in_ready", int'(in_ready), 1);
    check_val("reset out_valid", int'(out_valid), 0);
    check_val("reset out_sum", int'(out_sum), 0);
    check_val("reset out_bit", int'(out_bit), 0);

    // Full match: 32 agreeing bits; the result appears right after the 4th byte.
    send_eval(8'hA5, 8'hA5, 6'd16, 1'b0);
    check_val("latency out_valid", int'(out_valid), 1);
    check_output("full match", 32, 1);
    step();
    check_val("full match in_ready after", int'(in_ready), 1);

    // Full mismatch: sum 0, threshold 0 fires and threshold 1 does not.
    send_eval(8'h00, 8'hFF, 6'd0, 1'b1);
    check_output("mismatch th0", 0, 1);
    step();
    send_eval(8'h00, 8'hFF, 6'd1, 1'b0);
    check_output("mismatch th1", 0, 0);
    step();

    // Threshold boundary: 4 matches per byte gives 16.
    send_eval(8'hF0, 8'hFF, 6'd16, 1'b0);
    check_output("boundary th16", 16, 1);
    step();
    send_eval(8'hF0, 8'hFF, 6'd17, 1'b1);
    check_output("boundary th17", 16, 0);
    step();

    // Back-pressure: the result is held and the bytes offered meanwhile are ignored.
    out_ready = 1'b0;
    send_eval(8'hAA, 8'hAA, 6'd40, 1'b0);
    in_act = 8'h00;
    in_wgt = 8'h00;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_val("bp in_ready", int'(in_ready), 0);
      check_output("bp hold", 32, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_val("bp in_ready after", int'(in_ready), 1);
    check_val("bp out_valid after", int'(out_valid), 0);
    send_eval(8'h0F, 8'h00, 6'd10, 1'b0);
    check_output("after bp", 16, 1);
    step();

    // Reset during an evaluation that has 2 bytes accepted.
    apply_stimulus(8'hFF, 8'hFF, 6'd0);
    apply_stimulus(8'hFF, 8'hFF, 6'd0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_val("midrst in_ready", int'(in_ready), 1);
    check_val("midrst out_valid", int'(out_valid), 0);
    check_val("midrst out_sum", int'(out_sum), 0);
    check_val("midrst out_bit", int'(out_bit), 0);
    send_eval(8'h01, 8'h00, 6'd28, 1'b0);
    check_output("after rst", 28, 1);
    step();

    // Abort: 2 bytes, then clr together with a valid byte that must be dropped.
    apply_stimulus(8'h00, 8'h00, 6'd0);
    apply_stimulus(8'h00, 8'h00, 6'd0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_act = 8'hFF;
    in_wgt = 8'hFF;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    check_val("clr out_valid", int'(out_valid), 0);
    send_eval(8'hFF, 8'hFF, 6'd32, 1'b0);
    check_output("after clr", 32, 1);
    step();
    step();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bnn_xnor_neuron.md
# bnn_xnor_neuron

Serial binary-neuron stage for the BNN datapath: accepts packed 8-bit activation/weight byte pairs over a valid/ready handshake, XNORs them, popcounts and accumulates over a fixed fan-in, then thresholds the total into a 1-bit activation. It sits directly upstream of the output/combine stage and delivers one registered activation bit (plus its raw sum) per neuron evaluation.

## Interface
- N_BYTES, default 4: input bytes per evaluation; fan-in = 8*N_BYTES bits; legal range 1..16.
- SUM_W, default $clog2(8*N_BYTES+1) (6 for the default): width of accumulator, threshold and sum output.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous abort; discards any partial or held evaluation.
- in_valid  in  1  input byte pair valid.
- in_ready  out  1  stage can accept a byte pair.
- in_act  in  8  activation bits (1 = +1, 0 = −1).
- in_wgt  in  8  weight bits, same encoding.
- thresh  in  SUM_W  firing threshold; sampled on the cycle the last byte is accepted.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_bit  out  1  activation: 1 iff sum >= thresh.
- out_sum  out  SUM_W  final match count, 0..8*N_BYTES.

## Operation
- States: ACC (accumulating), HOLD (result presented).
- Handshake: byte pair transfers when in_valid && in_ready; result transfers when out_valid && out_ready.
- ACC: in_ready=1, out_valid=0. Each transfer adds popcount(~(in_act ^ in_wgt)) (0..8) to acc and increments byte counter cnt (0..N_BYTES−1).
- Transfer with cnt == N_BYTES−1: out_sum <= acc + pc; out_bit <= (acc + pc) >= thresh (unsigned, SUM_W bits, no overflow possible by construction); acc, cnt <= 0; go HOLD.
- HOLD: in_ready=0, out_valid=1; out_bit/out_sum stable until transfer. On out_ready → ACC next cycle.
- clr (either state): acc, cnt <= 0, out_valid <= 0, state <= ACC; an input transfer in the same cycle is discarded (clr wins). out_bit/out_sum retain last value.
- thresh = 0 → out_bit always 1; thresh > 8*N_BYTES → always 0.
- in_act/in_wgt/thresh ignored when no transfer occurs.

## Timing
- Reset values: state ACC, acc 0, cnt 0, in_ready 1 (from the first cycle after rst deasserts), out_valid 0, out_bit 0, out_sum 0. rst overrides clr and every handshake.
- rst mid-evaluation: all partial state discarded; next evaluation starts with cnt 0.
- in_ready is purely a function of state (registered), never combinational on out_ready or in_valid.
- Latency: out_valid rises the cycle after the last byte transfer.
- Throughput: N_BYTES+1 cycles per evaluation with out_ready held high (one HOLD cycle, no overlap); in_ready returns high the cycle after the result transfer.
- Back-pressure: out_ready low holds HOLD indefinitely; no input accepted meanwhile.
- in_valid gaps in ACC stall accumulation without loss; cnt only advances on transfers.

## Test plan
- Reset: rst high 2 cycles mid-stream (cnt=2) → in_ready=1, out_valid=0, out_bit=0, out_sum=0; a fresh 4-byte evaluation then completes normally.
- Full match: N_BYTES=4, 4× (act=0xA5, wgt=0xA5), thresh=16, out_ready=1 → out_valid one cycle after 4th transfer, out_sum=32, out_bit=1.
- Full mismatch: 4× (act=0x00, wgt=0xFF), thresh=0 → out_sum=0, out_bit=1; repeat with thresh=1 → out_bit=0.
- Threshold boundary: 4× (act=0xF0, wgt=0xFF) → out_sum=16; thresh=16 → out_bit=1; thresh=17 → out_bit=0.
- Back-pressure: complete evaluation with out_ready=0 for 5 cycles → out_valid, out_bit, out_sum stable, in_ready=0, input bytes offered meanwhile not consumed; out_ready=1 → transfer, in_ready=1 next cycle.
- Abort: 2 bytes accepted, then clr with in_valid=1 → that byte dropped; next 4 bytes of 0xFF/0xFF give out_sum=32 (no residue).
